relu_argmax_stage: RTL and testbench
====================================

// Module: relu_argmax_stage
// PURPOSE
//  Output stage directly downstream of the MAC neuron accumulator.
//  - Accepts one 16-bit signed accumulator result per output neuron (valid/ready).
//  - Per result: applies ReLU, an arithmetic right shift and saturation to 8 bits.
//  - Tracks the argmax over NUM_CLASSES neurons and reports the predicted digit class.
// PARAMETERS
//  ACC_WIDTH    16  accumulator input width, two's complement
//  OUT_WIDTH    8   requantized activation width, unsigned
//  NUM_CLASSES  10  results per frame (one per output neuron)
//  SHIFT        4   requantization right-shift amount, 0..ACC_WIDTH-1
//  localparam IDX_W = $clog2(NUM_CLASSES)   (4 at default)
// PORTS
//  CLKEXT     in   1          single clock, rising edge
//  RST_ACT    in   1          synchronous reset, active-high
//  START_ACT  in   1          1-cycle pulse: begin a new frame
//  acc_in     in   ACC_WIDTH  accumulator result from the MAC
//  acc_valid  in   1          acc_in is valid
//  acc_ready  out  1          stage accepts acc_in this cycle
//  act_out    out  OUT_WIDTH  requantized activation
//  act_valid  out  1          1-cycle pulse: act_out/act_idx valid
//  act_idx    out  IDX_W      neuron index of act_out
//  class_out  out  IDX_W      argmax index, held until next START_ACT
//  class_max  out  OUT_WIDTH  requantized activation of the winning neuron
//  done       out  1          1-cycle pulse: frame complete
//  busy       out  1          high in COLLECT
//  rd_idx     in   IDX_W      activation buffer read index (see CONFIGURATION)
//  rd_data    out  OUT_WIDTH  activation buffer read data
// BEHAVIOUR
//  Reset: state=IDLE; count=0; max=0.
//   All outputs 0: acc_ready, act_out, act_valid, act_idx, class_out, class_max, done, busy, rd_data.
//  FSM:
//  - IDLE -> COLLECT on START_ACT.
//  - COLLECT -> IDLE after the NUM_CLASSES-th accept.
//  - START_ACT in COLLECT restarts the frame:
//    - count=0, max cleared;
//    - the acc handshake in that same cycle is ignored.
//  Handshake:
//  - acc_ready = (state==COLLECT) && !START_ACT.
//  - Accept = acc_valid && acc_ready.
//  - acc_valid while not ready is ignored; there is no backpressure on outputs.
//  Requant: computed in the accept cycle, registered to act_out.
//  - acc_in < 0 -> 0.
//  - Otherwise v = acc_in >>> SHIFT; if v > 2^OUT_WIDTH-1 then 2^OUT_WIDTH-1, else v.
//  Latency: accept in cycle N -> act_out, act_valid=1, act_idx=count in cycle N+1.
//  Argmax: compares raw signed acc_in, not the requantized value.
//  - Index 0 always loads max.
//  - Later index replaces max only if strictly greater, so ties keep the lowest index.
//  Completion: accept of index NUM_CLASSES-1 in cycle N -> in cycle N+1:
//  - done=1 and the last act_valid pulse;
//  - class_out/class_max updated, including the final element;
//  - busy=0.
//  Wrap: count ends at NUM_CLASSES-1, then clears to 0; no out-of-range index is ever emitted.
//  class_out/class_max change only at done; they clear on START_ACT and on reset.
//  RST_ACT mid-frame: immediate return to reset values; the partial frame is discarded.
// CONFIGURATION
//  Macro ACT_BUF_EN.
//  - Defined: NUM_CLASSES x OUT_WIDTH register buffer.
//    - Written at index count on each accept, visible in the cycle after accept.
//    - rd_data = buf[rd_idx], combinational.
//    - rd_idx >= NUM_CLASSES -> rd_data = 0.
//    - Buffer cleared by reset only; START_ACT does not clear it.
//  - Undefined: no storage; rd_data tied to 0; rd_idx unused.
// TESTING  (defaults, SHIFT=4)
//  1. START_ACT, then 10 accepts with acc_in = 0x0010*i.
//     -> act_out = i; class_out=9, class_max=0x09; done 1 cycle after the 10th accept.
//  2. acc_in=0x7FFF -> act_out=0xFF (saturate).
//     acc_in=0x8000 -> 0x00 (ReLU).
//     acc_in=0x0123 -> 0x12.
//  3. Ties: idx2 and idx7 both 0x0500, others lower -> class_out=2, class_max=0x50.
//     All 10 negative -> class_out=index of least-negative value, class_max=0.
//  4. acc_valid toggled 1-of-3 cycles.
//     -> exactly 10 act_valid pulses, act_idx 0..9 in order.
//     acc_valid while IDLE -> no act_valid pulse.
//  5. RST_ACT after 5 accepts -> all outputs 0, no done.
//     START_ACT after 4 accepts -> frame restarts; done only after 10 further accepts.
//  6. ACT_BUF_EN defined: after test 1, rd_idx=3 -> rd_data=0x03; rd_idx=12 -> 0.
//     ACT_BUF_EN undefined: rd_data always 0.

Source files
------------

// File: rtl/relu_argmax_stage.sv
// relu_argmax_stage
//   Output stage behind the MAC neuron accumulator. It takes one signed
//   accumulator result per output neuron over a valid/ready handshake. Each
//   result is passed through ReLU, shifted right and saturated to an unsigned
//   activation. The stage also tracks which of NUM_CLASSES neurons has the
//   largest raw accumulator value and reports it as the predicted class.
//
// Optional feature: define ACT_BUF_EN to keep a readable buffer holding the
//   activations of the current/last frame. Without it rd_data is tied to 0.
//
// Ports
//   CLKEXT     clock, rising edge
//   RST_ACT    synchronous reset, active-high
//   START_ACT  1-cycle pulse: begin (or restart) a frame
//   acc_in     signed accumulator result
//   acc_valid  acc_in is valid
//   acc_ready  stage accepts acc_in this cycle
//   act_out    requantized activation
//   act_valid  1-cycle pulse: act_out/act_idx valid
//   act_idx    neuron index of act_out
//   class_out  argmax index of the last completed frame
//   class_max  requantized activation of the winning neuron
//   done       1-cycle pulse: frame complete
//   busy       frame collection in progress
//   rd_idx     activation buffer read index
//   rd_data    activation buffer read data (combinational)
module relu_argmax_stage #(
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SHIFT       = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic                 CLKEXT,
  input  logic                 RST_ACT,
  input  logic                 START_ACT,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  output logic [OUT_WIDTH-1:0] act_out,
  output logic                 act_valid,
  output logic [IDX_W-1:0]     act_idx,
  output logic [IDX_W-1:0]     class_out,
  output logic [OUT_WIDTH-1:0] class_max,
  output logic                 done,
  output logic                 busy,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [OUT_WIDTH-1:0] rd_data
);

  localparam logic [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'((2 ** OUT_WIDTH) - 1);
  localparam logic [IDX_W-1:0]     LastIdx = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                       state_q;
  logic [IDX_W-1:0]             count_q;
  logic signed [ACC_WIDTH-1:0]  max_q;
  logic [IDX_W-1:0]             max_idx_q;
  logic [OUT_WIDTH-1:0]         max_act_q;
  logic [OUT_WIDTH-1:0]         act_out_q;
  logic                         act_valid_q;
  logic [IDX_W-1:0]             act_idx_q;
  logic [IDX_W-1:0]             class_out_q;
  logic [OUT_WIDTH-1:0]         class_max_q;
  logic                         done_q;

  logic                         accept;
  logic                         is_last;
  logic                         take_max;
  logic [ACC_WIDTH-1:0]         shifted;
  logic [OUT_WIDTH-1:0]         act_d;
  logic [IDX_W-1:0]             win_idx;
  logic [OUT_WIDTH-1:0]         win_act;

  assign acc_ready = (state_q == StCollect) && !START_ACT;
  assign busy      = (state_q == StCollect);
  assign accept    = acc_valid && acc_ready;
  assign is_last   = (count_q == LastIdx);

  // ReLU, shift and saturate. After the sign test the value is non-negative,
  // so a logical shift equals the arithmetic one.
  always_comb begin
    shifted = acc_in >> SHIFT;
    act_d   = '0;
    if (acc_in[ACC_WIDTH-1]) begin
      act_d = '0;
    end else if (shifted > SatMax) begin
      act_d = '1;
    end else begin
      act_d = shifted[OUT_WIDTH-1:0];
    end
  end

  // Argmax on the raw signed value; index 0 always loads, ties keep the
  // earlier index because only a strictly greater value replaces it.
  always_comb begin
    take_max = (count_q == '0) || ($signed(acc_in) > max_q);
    win_idx  = take_max ? count_q : max_idx_q;
    win_act  = take_max ? act_d   : max_act_q;
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_ACT) begin
      state_q     <= StIdle;
      count_q     <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      max_act_q   <= '0;
      act_out_q   <= '0;
      act_valid_q <= 1'b0;
      act_idx_q   <= '0;
      class_out_q <= '0;
      class_max_q <= '0;
      done_q      <= 1'b0;
    end else begin
      act_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (START_ACT) begin
        state_q     <= StCollect;
        count_q     <= '0;
        max_q       <= '0;
        max_idx_q   <= '0;
        max_act_q   <= '0;
        class_out_q <= '0;
        class_max_q <= '0;
      end else if (accept) begin
        act_out_q   <= act_d;
        act_valid_q <= 1'b1;
        act_idx_q   <= count_q;
        if (take_max) begin
          max_q     <= $signed(acc_in);
          max_idx_q <= count_q;
          max_act_q <= act_d;
        end
        if (is_last) begin
          state_q     <= StIdle;
          count_q     <= '0;
          done_q      <= 1'b1;
          class_out_q <= win_idx;
          class_max_q <= win_act;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign act_out   = act_out_q;
  assign act_valid = act_valid_q;
  assign act_idx   = act_idx_q;
  assign class_out = class_out_q;
  assign class_max = class_max_q;
  assign done      = done_q;

`ifdef ACT_BUF_EN
  logic [OUT_WIDTH-1:0] buf_q [NUM_CLASSES];

  // Only reset clears the buffer; a new frame overwrites entries as it goes.
  always_ff @(posedge CLKEXT) begin
    if (RST_ACT) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      buf_q[count_q] <= act_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_CLASSES) begin
      rd_data = buf_q[rd_idx];
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_relu_argmax_stage.sv
// Randomized self-checking bench for relu_argmax_stage with a frame-level
// reference model: accepted values are collected per frame, requantized with
// integer arithmetic and the argmax is found by scanning the finished frame.
module tb_relu_argmax_stage;

  localparam int NC    = 10;
  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] acc_in = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [7:0]  act_out;
  logic        act_valid;
  logic [3:0]  act_idx;
  logic [3:0]  class_out;
  logic [7:0]  class_max;
  logic        done;
  logic        busy;
  logic [3:0]  rd_idx = '0;
  logic [7:0]  rd_data;

  relu_argmax_stage dut (
    .CLKEXT    (clk),
    .RST_ACT   (rst),
    .START_ACT (start),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .act_out   (act_out),
    .act_valid (act_valid),
    .act_idx   (act_idx),
    .class_out (class_out),
    .class_max (class_max),
    .done      (done),
    .busy      (busy),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model state.
  bit m_busy = 1'b0;
  int m_vals[$];
  int m_class = 0;
  int m_cmax  = 0;
  int m_buf[NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int quant(input int v);
    int r;
    if (v < 0) return 0;
    r = v / (1 << SHIFT);
    if (r > 255) return 255;
    return r;
  endfunction

  function automatic int exp_rd(input int idx);
`ifdef ACT_BUF_EN
    if (idx < NC) return m_buf[idx];
    return 0;
`else
    return 0 + (idx * 0);
`endif
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; acc_valid = 1'b1; acc_in = 16'h7fff;
    @(posedge clk); #1;
    m_busy = 1'b0; m_vals.delete(); m_class = 0; m_cmax = 0;
    for (int i = 0; i < NC; i++) m_buf[i] = 0;
    check("rst_acc_ready", 32'(acc_ready), 0);
    check("rst_act_out",   32'(act_out),   0);
    check("rst_act_valid", 32'(act_valid), 0);
    check("rst_act_idx",   32'(act_idx),   0);
    check("rst_class_out", 32'(class_out), 0);
    check("rst_class_max", 32'(class_max), 0);
    check("rst_done",      32'(done),      0);
    check("rst_busy",      32'(busy),      0);
    check("rst_rd_data",   32'(rd_data),   0);
    @(negedge clk);
    rst = 1'b0; acc_valid = 1'b0;
  endtask

  // One clock cycle of stimulus, with model update and output checks.
  task automatic step(input bit st, input bit valid, input int v);
    bit e_ready, e_act_valid, e_done;
    int e_act, e_idx, best;
    @(negedge clk);
    start = st; acc_valid = valid; acc_in = 16'(v);
    rd_idx = 4'($urandom_range(0, 15));
    #1;
    e_ready = m_busy && !st;
    check("acc_ready", 32'(acc_ready), 32'(e_ready));
    check("rd_data", 32'(rd_data), 32'(exp_rd(int'(rd_idx))));
    e_act_valid = 1'b0; e_done = 1'b0; e_act = 0; e_idx = 0;
    if (st) begin
      m_busy = 1'b1; m_vals.delete(); m_class = 0; m_cmax = 0;
    end else if (e_ready && valid) begin
      e_act_valid = 1'b1;
      e_act = quant(v);
      e_idx = m_vals.size();
      m_buf[e_idx] = e_act;
      m_vals.push_back(v);
      if (m_vals.size() == NC) begin
        best = 0;
        for (int i = 1; i < NC; i++) if (m_vals[i] > m_vals[best]) best = i;
        m_class = best;
        m_cmax  = quant(m_vals[best]);
        e_done  = 1'b1;
        m_busy  = 1'b0;
        m_vals.delete();
      end
    end
    @(posedge clk); #1;
    if (act_valid === 1'b1) pulses++;
    check("act_valid", 32'(act_valid), 32'(e_act_valid));
    check("done",      32'(done),      32'(e_done));
    check("busy",      32'(busy),      32'(m_busy));
    check("class_out", 32'(class_out), 32'(m_class));
    check("class_max", 32'(class_max), 32'(m_cmax));
    if (e_act_valid) begin
      check("act_out", 32'(act_out), 32'(e_act));
      check("act_idx", 32'(act_idx), 32'(e_idx));
    end
  endtask

  task automatic rd_check(input string tag, input logic [3:0] idx, input int exp);
    @(negedge clk);
    start = 1'b0; acc_valid = 1'b0; rd_idx = idx;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  function automatic int rand_val();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0: return 'h0500;
      1: return -1;
      2: return 'h7fff;
      3: return int'($urandom_range(0, 'h0fff));
      default: begin
        r = 16'($urandom);
        return int'($signed(r));
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NC; i++) m_buf[i] = 0;
    reset_dut();

    // Ramp frame: act_out = i, winner is the last index.
    step(1, 0, 0);
    for (int i = 0; i < NC; i++) step(0, 1, 'h10 * i);
    check("t1_class_out", 32'(class_out), 9);
    check("t1_class_max", 32'(class_max), 'h09);
`ifdef ACT_BUF_EN
    rd_check("t6_rd3", 4'd3, 'h03);
`else
    rd_check("t6_rd3", 4'd3, 0);
`endif
    rd_check("t6_rd12", 4'd12, 0);

    // Saturation, ReLU, plain shift.
    step(1, 0, 0);
    step(0, 1, 'h7fff);
    check("t2_sat", 32'(act_out), 'hff);
    step(0, 1, -32768);
    check("t2_relu", 32'(act_out), 'h00);
    step(0, 1, 'h0123);
    check("t2_shift", 32'(act_out), 'h12);
    for (int i = 3; i < NC; i++) step(0, 1, i);

    // Ties keep the lowest index.
    step(1, 0, 0);
    for (int i = 0; i < NC; i++) step(0, 1, (i == 2 || i == 7) ? 'h0500 : 'h0100 + i);
    check("t3_tie_class", 32'(class_out), 2);
    check("t3_tie_max",   32'(class_max), 'h50);

    // All negative: least-negative wins, activation 0.
    step(1, 0, 0);
    for (int i = 0; i < NC; i++) step(0, 1, (i == 6) ? -5 : -1000 - i);
    check("t3_neg_class", 32'(class_out), 6);
    check("t3_neg_max",   32'(class_max), 0);

    // Valid while idle is ignored; sparse valid gives 10 ordered pulses.
    for (int i = 0; i < 3; i++) step(0, 1, 'h0200);
    pulses = 0;
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, (i % 3) == 0, 'h0040 + i);
    check("t4_pulses", 32'(pulses), 10);

    // Reset mid-frame, then restart mid-frame.
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 'h0300);
    reset_dut();
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 'h0700);
    step(1, 1, 'h7000);
    for (int i = 0; i < NC; i++) step(0, 1, 'h0020 * (NC - i));
    check("t5_class_out", 32'(class_out), 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_dut();
      end else begin
        step(m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0),
             $urandom_range(0, 2) != 0, rand_val());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
